// File: rtl/proc_debug_ctrl.sv
// Run/debug sequencer between the host command path and the single-cycle MIPS core.
// Optional breakpoint support is enabled with `define PROC_DEBUG_CTRL_BKPT_EN.
module proc_debug_ctrl #(
  parameter int                REG_NUM    = 32,
  parameter int                ADDR_W     = 5,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] PC_STOP    = 32'h48,
  parameter int                RST_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_i,
  input  logic [DATA_W-1:0] cmd_arg_i,
  input  logic [DATA_W-1:0] pc_i,
  output logic              proc_run_en_o,
  output logic              proc_reset_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_last_o,
  output logic              halted_o,
  output logic              stop_hit_o
);

  typedef enum logic [2:0] {
    S_RESET, S_IDLE, S_RUN, S_STEP, S_DUMP_RD, S_DUMP_TX
  } state_t;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_RUN   = 3'd1,
    CMD_STEP  = 3'd2,
    CMD_HALT  = 3'd3,
    CMD_RESET = 3'd4,
    CMD_DUMP  = 3'd5,
    CMD_SETBP = 3'd6,
    CMD_CLRBP = 3'd7
  } cmd_t;

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(REG_NUM - 1);

  state_t           state;
  logic [CNT_W-1:0] rst_cnt;
  cmd_t             cmd;
  logic             cmd_fire;
  logic             pc_stop;
  logic             bp_hit;

  assign cmd      = cmd_t'(cmd_i);
  assign cmd_fire = cmd_valid_i && cmd_ready_o;
  assign pc_stop  = (pc_i == PC_STOP);

  // NOTE: run enable is decoded combinationally from pc_i so the core is
  // gated in the very cycle it reaches the stop PC, never one instruction late.
  assign proc_run_en_o = (((state == S_RUN) && !bp_hit) || (state == S_STEP)) && !pc_stop;
  assign proc_reset_o  = (state == S_RESET);
  assign cmd_ready_o   = (state == S_IDLE) || (state == S_RUN);
  assign dump_valid_o  = (state == S_DUMP_TX);
  assign halted_o      = (state == S_IDLE);

  // NOTE: all sequential state uses non-blocking assignments, and reset is
  // tested first so it overrides any command or handshake in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state       <= S_RESET;
      rst_cnt     <= '0;
      reg_addr_o  <= '0;
      dump_data_o <= '0;
      dump_last_o <= 1'b0;
      stop_hit_o  <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          stop_hit_o <= 1'b0;
          if (rst_cnt == CNT_LAST) state <= S_IDLE;
          else                     rst_cnt <= rst_cnt + CNT_W'(1);
        end
        S_IDLE: begin
          if (cmd_fire) begin
            case (cmd)
              CMD_RUN:   begin state <= S_RUN;  stop_hit_o <= 1'b0; end
              CMD_STEP:  begin state <= S_STEP; stop_hit_o <= 1'b0; end
              CMD_RESET: begin state <= S_RESET; rst_cnt <= '0; end
              CMD_DUMP:  begin state <= S_DUMP_RD; reg_addr_o <= '0; end
              default:   ;
            endcase
          end
        end
        S_RUN: begin
          if (cmd_fire && (cmd == CMD_RESET)) begin
            state   <= S_RESET;
            rst_cnt <= '0;
          end else if (pc_stop || bp_hit) begin
            state      <= S_IDLE;
            stop_hit_o <= 1'b1;
          end else if (cmd_fire && (cmd == CMD_HALT)) begin
            state <= S_IDLE;
          end
        end
        S_STEP: begin
          state <= S_IDLE;
          if (pc_stop) stop_hit_o <= 1'b1;
        end
        S_DUMP_RD: begin
          dump_data_o <= reg_rdata_i;
          dump_last_o <= (reg_addr_o == ADDR_LAST);
          state       <= S_DUMP_TX;
        end
        S_DUMP_TX: begin
          if (dump_ready_i) begin
            if (dump_last_o) begin
              state       <= S_IDLE;
              reg_addr_o  <= '0;
              dump_last_o <= 1'b0;
            end else begin
              state      <= S_DUMP_RD;
              reg_addr_o <= reg_addr_o + ADDR_W'(1);
            end
          end
        end
        default: begin
          state   <= S_RESET;
          rst_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PROC_DEBUG_CTRL_BKPT_EN
  logic [DATA_W-1:0] bp_addr;
  logic              bp_valid;
  logic              bp_stopped;
  logic              skip_bp;

  // skip_bp masks the breakpoint for the first RUN cycle after a breakpoint
  // stop, giving the core one forced step off the breakpoint PC.
  assign bp_hit = bp_valid && !skip_bp && (pc_i == bp_addr);

  always_ff @(posedge clk_i) begin
    if (rst) begin
      bp_addr    <= '0;
      bp_valid   <= 1'b0;
      bp_stopped <= 1'b0;
      skip_bp    <= 1'b0;
    end else begin
      if ((state == S_IDLE) && cmd_fire) begin
        case (cmd)
          CMD_SETBP: begin bp_addr <= cmd_arg_i; bp_valid <= 1'b1; end
          CMD_CLRBP: bp_valid <= 1'b0;
          CMD_RUN:   begin skip_bp <= bp_stopped; bp_stopped <= 1'b0; end
          CMD_STEP:  bp_stopped <= 1'b0;
          default:   ;
        endcase
      end
      if (state == S_RUN) begin
        skip_bp <= 1'b0;
        if (bp_hit && !(cmd_fire && (cmd == CMD_RESET))) bp_stopped <= 1'b1;
      end
      if (state == S_RESET) bp_stopped <= 1'b0;
    end
  end
`else
  logic unused_cmd_arg;

  assign bp_hit         = 1'b0;
  assign unused_cmd_arg = ^cmd_arg_i;
`endif

endmodule

// File: tb/tb_proc_debug_ctrl.sv
// Self-checking bench for proc_debug_ctrl: behavioural core PC model, regfile
// model reg[i]=i*0x11, command-decode vector table and a dump scoreboard.
module tb_proc_debug_ctrl;

  localparam int          ADDR_W  = 5;
  localparam int          DATA_W  = 32;
  localparam int          REG_NUM = 32;
  localparam logic [31:0] PC_STOP = 32'h48;

  logic              clk_i = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid_i = 1'b0;
  logic              cmd_ready_o;
  logic [2:0]        cmd_i = 3'd0;
  logic [DATA_W-1:0] cmd_arg_i = '0;
  logic [DATA_W-1:0] pc_i;
  logic              proc_run_en_o;
  logic              proc_reset_o;
  logic [ADDR_W-1:0] reg_addr_o;
  logic [DATA_W-1:0] reg_rdata_i;
  logic              dump_valid_o;
  logic              dump_ready_i = 1'b0;
  logic [DATA_W-1:0] dump_data_o;
  logic              dump_last_o;
  logic              halted_o;
  logic              stop_hit_o;

  proc_debug_ctrl dut (
    .clk_i        (clk_i),
    .rst          (rst),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_i        (cmd_i),
    .cmd_arg_i    (cmd_arg_i),
    .pc_i         (pc_i),
    .proc_run_en_o(proc_run_en_o),
    .proc_reset_o (proc_reset_o),
    .reg_addr_o   (reg_addr_o),
    .reg_rdata_i  (reg_rdata_i),
    .dump_valid_o (dump_valid_o),
    .dump_ready_i (dump_ready_i),
    .dump_data_o  (dump_data_o),
    .dump_last_o  (dump_last_o),
    .halted_o     (halted_o),
    .stop_hit_o   (stop_hit_o)
  );

  always #5 clk_i = ~clk_i;

  // Core model: PC advances by 4 on each enabled cycle, clears on core reset.
  logic [31:0] core_pc = 32'h0;
  logic        pc_force = 1'b0;
  logic [31:0] pc_forced = 32'h0;

  always @(posedge clk_i) begin
    if (proc_reset_o)       core_pc <= 32'h0;
    else if (proc_run_en_o) core_pc <= core_pc + 32'd4;
  end

  assign pc_i        = pc_force ? pc_forced : core_pc;
  assign reg_rdata_i = 32'(reg_addr_o) * 32'h11;

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] pc;
    logic        run_en;
    logic        halted;
    logic        preset;
    logic        ready;
  } vec_t;

  vec_t        vecs [9];
  logic [32:0] sb [$];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [31:0] a);
    cmd_i       = c;
    cmd_arg_i   = a;
    cmd_valid_i = 1'b1;
    next();
    cmd_valid_i = 1'b0;
    cmd_i       = 3'd0;
    cmd_arg_i   = '0;
  endtask

  task automatic wait_halted(input int bound);
    int i = 0;
    mid();
    while (!halted_o && i < bound) begin
      next();
      mid();
      i++;
    end
    check("wait_halted", halted_o, 1);
    next();
  endtask

  initial begin
    int pulses;
    int hs;

    //          cmd   pc      run hlt rst rdy
    vecs[0] = '{3'd0, 32'h10, 0,  1,  0,  1};
    vecs[1] = '{3'd3, 32'h10, 0,  1,  0,  1};
    vecs[2] = '{3'd6, 32'h10, 0,  1,  0,  1};
    vecs[3] = '{3'd7, 32'h10, 0,  1,  0,  1};
    vecs[4] = '{3'd1, 32'h10, 1,  0,  0,  1};
    vecs[5] = '{3'd1, 32'h48, 0,  0,  0,  1};
    vecs[6] = '{3'd2, 32'h10, 1,  0,  0,  0};
    vecs[7] = '{3'd2, 32'h48, 0,  0,  0,  0};
    vecs[8] = '{3'd4, 32'h10, 0,  0,  1,  0};

    // Reset: 3 cycles of rst, then proc_reset_o for 4 more cycles.
    repeat (3) @(posedge clk_i);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("rst_proc_reset", proc_reset_o, 1);
      check("rst_run_en", proc_run_en_o, 0);
      check("rst_halted", halted_o, 0);
      if (i == 0) begin
        check("rst_reg_addr", reg_addr_o, 0);
        check("rst_dump_valid", dump_valid_o, 0);
        check("rst_dump_data", dump_data_o, 0);
        check("rst_dump_last", dump_last_o, 0);
        check("rst_stop_hit", stop_hit_o, 0);
        check("rst_cmd_ready", cmd_ready_o, 0);
      end
      next();
    end
    mid();
    check("post_rst_halted", halted_o, 1);
    check("post_rst_proc_reset", proc_reset_o, 0);
    check("post_rst_run_en", proc_run_en_o, 0);
    next();

    // RUN with the core model ramping the PC up to the stop address.
    send_cmd(3'd1, 0);
    for (int k = 0; k < 40; k++) begin
      mid();
      check("ramp_run_en", proc_run_en_o, (pc_i != PC_STOP));
      if (pc_i == PC_STOP) break;
      next();
    end
    check("ramp_final_pc", pc_i, PC_STOP);
    next();
    mid();
    check("ramp_halted", halted_o, 1);
    check("ramp_stop_hit", stop_hit_o, 1);
    next();

    // STEP twice at 0x10, then once at the stop PC.
    pc_force  = 1'b1;
    pc_forced = 32'h10;
    for (int s = 0; s < 2; s++) begin
      send_cmd(3'd2, 0);
      pulses = 0;
      repeat (3) begin
        mid();
        if (proc_run_en_o) pulses++;
        next();
      end
      check("step_pulses", pulses, 1);
      check("step_stop_hit", stop_hit_o, 0);
    end
    pc_forced = PC_STOP;
    send_cmd(3'd2, 0);
    pulses = 0;
    repeat (3) begin
      mid();
      if (proc_run_en_o) pulses++;
      next();
    end
    check("step_end_pulses", pulses, 0);
    check("step_end_stop_hit", stop_hit_o, 1);
    check("step_end_halted", halted_o, 1);

    // Command decode table: outputs in the cycle after acceptance from IDLE.
    foreach (vecs[v]) begin
      pc_forced = vecs[v].pc;
      send_cmd(vecs[v].cmd, 0);
      mid();
      check($sformatf("vec%0d_run_en", v), proc_run_en_o, vecs[v].run_en);
      check($sformatf("vec%0d_halted", v), halted_o, vecs[v].halted);
      check($sformatf("vec%0d_proc_reset", v), proc_reset_o, vecs[v].preset);
      check($sformatf("vec%0d_cmd_ready", v), cmd_ready_o, vecs[v].ready);
      next();
      if (cmd_ready_o) send_cmd(3'd3, 0);
      wait_halted(10);
    end

    // DUMP with a consumer whose ready toggles every 3 cycles.
    for (int i = 0; i < REG_NUM; i++)
      sb.push_back({(i == REG_NUM - 1) ? 1'b1 : 1'b0, 32'(i) * 32'h11});
    send_cmd(3'd5, 0);
    for (int k = 0; k < 400; k++) begin
      dump_ready_i = ((k / 3) % 2) == 1;
      mid();
      if (dump_valid_o) begin
        if (sb.size() == 0) begin
          check("dump_extra_word", dump_valid_o, 0);
        end else begin
          check("dump_data", dump_data_o, sb[0][31:0]);
          check("dump_last", dump_last_o, sb[0][32]);
          if (dump_ready_i) void'(sb.pop_front());
        end
      end
      next();
      if (sb.size() == 0) break;
    end
    dump_ready_i = 1'b0;
    check("dump_remaining", sb.size(), 0);
    mid();
    check("dump_done_halted", halted_o, 1);
    check("dump_done_reg_addr", reg_addr_o, 0);
    check("dump_done_valid", dump_valid_o, 0);
    next();

    // HALT during RUN at 0x20.
    pc_forced = 32'h20;
    send_cmd(3'd1, 0);
    mid();
    check("halt_run_en_before", proc_run_en_o, 1);
    next();
    send_cmd(3'd3, 0);
    mid();
    check("halt_run_en_after", proc_run_en_o, 0);
    check("halt_halted", halted_o, 1);
    check("halt_stop_hit", stop_hit_o, 0);
    next();

    // rst in the middle of a dump aborts it.
    send_cmd(3'd5, 0);
    dump_ready_i = 1'b1;
    hs = 0;
    for (int k = 0; k < 20; k++) begin
      mid();
      if (dump_valid_o) hs++;
      next();
      if (hs == 3) break;
    end
    check("abort_handshakes", hs, 3);
    rst = 1'b1;
    next();
    rst = 1'b0;
    dump_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("abort_dump_valid", dump_valid_o, 0);
      check("abort_proc_reset", proc_reset_o, 1);
      check("abort_run_en", proc_run_en_o, 0);
      check("abort_reg_addr", reg_addr_o, 0);
      next();
    end
    mid();
    check("abort_halted", halted_o, 1);
    check("abort_proc_reset_end", proc_reset_o, 0);
    next();

`ifdef PROC_DEBUG_CTRL_BKPT_EN
    // Breakpoint at 0x18, then resume with a forced step to the program end.
    pc_force = 1'b0;
    send_cmd(3'd4, 0);
    wait_halted(10);
    send_cmd(3'd6, 32'h18);
    send_cmd(3'd1, 0);
    wait_halted(40);
    check("bp_stop_pc", pc_i, 32'h18);
    check("bp_stop_hit", stop_hit_o, 1);
    send_cmd(3'd1, 0);
    mid();
    check("bp_forced_step_run_en", proc_run_en_o, 1);
    check("bp_forced_step_pc", pc_i, 32'h18);
    next();
    wait_halted(60);
    check("bp_resume_pc", pc_i, PC_STOP);
    check("bp_resume_stop_hit", stop_hit_o, 1);
    send_cmd(3'd7, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
